sdram_fifo_ctrl_param: RTL and testbench
========================================

Name: sdram_fifo_ctrl_param

Overview:
- Parametrised successor of the single-channel SDRAM FIFO controller. It buffers user write data toward SDRAM and SDRAM read data toward the user, each through an internal synchronous FIFO.
- Generates level-driven burst requests to the SDRAM arbiter, with fair write/read alternation and wrapping region addresses.
- Adds error flags and a runtime address reload.
- Sits between user logic and the SDRAM arbiter, in a single clock domain.

Parameters:
- DW, 16: data width of user and SDRAM data paths.
- AW, 23: SDRAM word address width.
- DEPTH, 512: entries per FIFO; power of two, at least 4.
- LW, 8: width of the burst-length inputs; maximum burst is 2^LW-1, and that maximum must not exceed DEPTH.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- init_end  in  1  SDRAM initialisation done; no requests are issued while low.
- rd_enable  in  1  read-side enable; read requests are issued only while high.
- addr_reload  in  1  one-cycle pulse: load begin addresses into both address counters.
- err_clr  in  1  one-cycle pulse: clear the sticky error flags.
- wr_b_addr, wr_e_addr  in  AW  write region: begin inclusive, end exclusive.
- rd_b_addr, rd_e_addr  in  AW  read region: begin inclusive, end exclusive.
- wr_burst_len, rd_burst_len  in  LW  words per burst; 0 disables that direction.
- wr_fifo_wr_data  in  DW  user write data.
- wr_fifo_wr_req  in  1  user push.
- wr_fifo_num  out  log2(DEPTH)+1  write FIFO fill level.
- rd_fifo_rd_req  in  1  user pop.
- rd_fifo_rd_data  out  DW  read FIFO head data.
- rd_fifo_num  out  log2(DEPTH)+1  read FIFO fill level.
- sdram_wr_req  out  1  write burst request to arbiter.
- sdram_wr_ack  in  1  arbiter write data phase; high for exactly wr_burst_len cycles.
- sdram_wr_addr  out  AW  write burst start address.
- sdram_in_data  out  DW  write FIFO head data, presented to SDRAM.
- sdram_rd_req  out  1  read burst request to arbiter.
- sdram_rd_ack  in  1  arbiter read data phase; one valid word per high cycle.
- sdram_rd_addr  out  AW  read burst start address.
- sdram_out_data  in  DW  SDRAM read data.
- wr_ovf  out  1  sticky: a push was attempted on a full write FIFO.
- rd_udf  out  1  sticky: a pop was attempted on an empty read FIFO.

Behaviour:
Reset values:
- All request outputs, levels and error flags reset to 0.
- Address counters reset to their b_addr values.
- FSM resets to IDLE; last_served resets to RD, so the first grant goes to write.

FIFOs:
- Each is show-ahead: q always equals the head entry. A pop advances the head on the next edge.
- A push writes on the edge. The level is registered and updated on the same edge.
- Simultaneous push and pop: the level is unchanged and both take effect.
- Push when full is dropped and sets wr_ovf.
- Pop when empty is ignored, q holds its value, and rd_udf is set.
- Write FIFO: pop = sdram_wr_ack. Read FIFO: push = sdram_rd_ack.

Eligibility, evaluated in IDLE:
- wr_ok = init_end & wr_burst_len!=0 & wr_fifo_num >= wr_burst_len.
- rd_ok = init_end & rd_enable & rd_burst_len!=0 & (DEPTH - rd_fifo_num) >= rd_burst_len.

FSM states: IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER.
- IDLE: if both wr_ok and rd_ok, grant the direction opposite last_served; otherwise grant whichever is eligible. The request output rises on the edge leaving IDLE.
- WR_REQ: sdram_wr_req held high until sdram_wr_ack is sampled high, then go to WR_XFER. The request drops on that same edge.
- WR_XFER: on the first cycle with sdram_wr_ack low:
  - advance the write address;
  - set last_served = WR;
  - return to IDLE.
  One idle cycle is guaranteed between bursts.
- RD_REQ and RD_XFER: symmetric, using sdram_rd_* signals and rd_burst_len.
- At most one request output is high at any time.

Address advance (computed in AW+1 bits, no overflow):
- nxt = addr + len.
- If nxt + len > e_addr, then addr = b_addr; else addr = nxt.
- A burst never crosses e_addr.

Other rules:
- sdram_*_addr is stable from request assertion through the end of the transfer.
- addr_reload applied while not in IDLE is deferred and applied when the FSM returns to IDLE. An advance on that same edge is overridden by the reload.
- err_clr has priority below a same-cycle new error: the flag stays set.
- Reset asserted mid-burst: both FIFOs empty, FSM to IDLE, requests drop asynchronously.
- The ack-length contract is the arbiter's. Extra ack cycles on an empty FIFO set no flags and corrupt no state.

Decomposition:
- Shared package: FSM state enum, direction enum {WR,RD}, and a clog2-based level-width function.
- One sub-module, sdram_sync_fifo: parametrised DW/DEPTH, show-ahead, registered level, full/empty outputs. It is instantiated twice.
- Arbitration, FSM and address counters live in the top module.

Test Plan:
1. Reset, init_end=1, wr_burst_len=8, push 8 words 0x0001..0x0008 -> sdram_wr_req rises 1 cycle after the 8th push. After 8 ack cycles, sdram_in_data sequence equals 0x0001..0x0008, wr_fifo_num=0, and sdram_wr_addr advances from b_addr to b_addr+8.
2. Write region b=0x100, e=0x118, len=8 -> addresses 0x100, 0x108, 0x110, then wrap to 0x100. With e=0x114, the sequence is 0x100, 0x108, 0x100.
3. Both directions eligible continuously (write FIFO ≥8, read FIFO empty, rd_enable=1) -> grants alternate WR, RD, WR, RD, starting with WR. The two requests are never high together.
4. Fill the write FIFO to DEPTH then push once more -> wr_ovf=1 and level stays DEPTH. Pop the read FIFO at level 0 -> rd_udf=1. err_clr -> both flags 0.
5. rd_burst_len=16, read FIFO level DEPTH-15 -> no sdram_rd_req. Pop one word -> request on the following cycle. rd_enable=0 blocks the request regardless of level.
6. Assert sys_rst during cycle 4 of an 8-cycle write transfer -> requests drop immediately; after release levels are 0, addresses are b_addr, and FSM is IDLE. An addr_reload pulse during a transfer takes effect only on return to IDLE.

Source files
------------

// File: rtl/sdram_fifo_ctrl_param_pkg.sv
// Shared state encodings, direction type and sizing helper for the
// parametrised SDRAM FIFO controller.
package sdram_fifo_ctrl_param_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_XFER = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_XFER = 3'd4;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } dir_t;

    // Level counters need one extra bit so that "full" (== DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdram_fifo_ctrl_param_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered fill level; overflowing pushes
// and underflowing pops are silently ignored here and flagged by the parent.
module sdram_sync_fifo
    import sdram_fifo_ctrl_param_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 512
)
(
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      push,
    input  logic [DW-1:0]             wr_data,
    input  logic                      pop,
    output logic [DW-1:0]             q,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      empty
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LVW = lvl_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LVW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign q       = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVW'(1);
                2'b01:   level <= level - LVW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sdram_fifo_ctrl_param.sv
// Single-channel SDRAM FIFO controller: buffers user data both ways and issues
// alternating write/read burst requests over wrapping address regions.
module sdram_fifo_ctrl_param
    import sdram_fifo_ctrl_param_pkg::*;
#(
    parameter int DW    = 16,
    parameter int AW    = 23,
    parameter int DEPTH = 512,
    parameter int LW    = 8
)
(
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      init_end,
    input  logic                      rd_enable,
    input  logic                      addr_reload,
    input  logic                      err_clr,
    input  logic [AW-1:0]             wr_b_addr,
    input  logic [AW-1:0]             wr_e_addr,
    input  logic [AW-1:0]             rd_b_addr,
    input  logic [AW-1:0]             rd_e_addr,
    input  logic [LW-1:0]             wr_burst_len,
    input  logic [LW-1:0]             rd_burst_len,
    input  logic [DW-1:0]             wr_fifo_wr_data,
    input  logic                      wr_fifo_wr_req,
    output logic [lvl_w(DEPTH)-1:0]   wr_fifo_num,
    input  logic                      rd_fifo_rd_req,
    output logic [DW-1:0]             rd_fifo_rd_data,
    output logic [lvl_w(DEPTH)-1:0]   rd_fifo_num,
    output logic                      sdram_wr_req,
    input  logic                      sdram_wr_ack,
    output logic [AW-1:0]             sdram_wr_addr,
    output logic [DW-1:0]             sdram_in_data,
    output logic                      sdram_rd_req,
    input  logic                      sdram_rd_ack,
    output logic [AW-1:0]             sdram_rd_addr,
    input  logic [DW-1:0]             sdram_out_data,
    output logic                      wr_ovf,
    output logic                      rd_udf
);

    localparam int              LVW     = lvl_w(DEPTH);
    localparam logic [LVW-1:0]  DEPTH_L = LVW'(DEPTH);

    logic [2:0]     state;
    dir_t           last_served;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic           reload_pend;
    logic           wr_full, wr_empty, rd_full, rd_empty;
    logic           wr_ok, rd_ok;
    logic [LVW-1:0] wr_len_l, rd_len_l;
    logic           wr_done, rd_done, reload_now;

    // Next burst start; wraps to begin when the following burst would cross end.
    function automatic logic [AW-1:0] advance(input logic [AW-1:0] addr,
                                              input logic [AW-1:0] b_addr,
                                              input logic [AW-1:0] e_addr,
                                              input logic [LW-1:0] len);
        logic [AW:0] len_x;
        logic [AW:0] nxt;
        len_x = {{(AW+1-LW){1'b0}}, len};
        nxt   = {1'b0, addr} + len_x;
        if (nxt + len_x > {1'b0, e_addr})
            return b_addr;
        return nxt[AW-1:0];
    endfunction

    sdram_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_wr_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (wr_fifo_wr_req),
        .wr_data (wr_fifo_wr_data),
        .pop     (sdram_wr_ack),
        .q       (sdram_in_data),
        .level   (wr_fifo_num),
        .full    (wr_full),
        .empty   (wr_empty)
    );

    sdram_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rd_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (sdram_rd_ack),
        .wr_data (sdram_out_data),
        .pop     (rd_fifo_rd_req),
        .q       (rd_fifo_rd_data),
        .level   (rd_fifo_num),
        .full    (rd_full),
        .empty   (rd_empty)
    );

    assign wr_len_l   = {{(LVW-LW){1'b0}}, wr_burst_len};
    assign rd_len_l   = {{(LVW-LW){1'b0}}, rd_burst_len};
    assign wr_ok      = init_end & (wr_burst_len != '0) & ~wr_empty & (wr_fifo_num >= wr_len_l);
    assign rd_ok      = init_end & rd_enable & (rd_burst_len != '0) & ~rd_full
                        & ((DEPTH_L - rd_fifo_num) >= rd_len_l);
    assign wr_done    = (state == ST_WR_XFER) & ~sdram_wr_ack;
    assign rd_done    = (state == ST_RD_XFER) & ~sdram_rd_ack;
    assign reload_now = ((wr_done | rd_done) & (reload_pend | addr_reload))
                        | ((state == ST_IDLE) & addr_reload);

    assign sdram_wr_req  = (state == ST_WR_REQ);
    assign sdram_rd_req  = (state == ST_RD_REQ);
    assign sdram_wr_addr = wr_addr;
    assign sdram_rd_addr = rd_addr;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            last_served <= DIR_RD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok && (!rd_ok || last_served == DIR_RD))
                        state <= ST_WR_REQ;
                    else if (rd_ok)
                        state <= ST_RD_REQ;
                end
                ST_WR_REQ:  if (sdram_wr_ack) state <= ST_WR_XFER;
                ST_WR_XFER: if (!sdram_wr_ack) begin
                    state       <= ST_IDLE;
                    last_served <= DIR_WR;
                end
                ST_RD_REQ:  if (sdram_rd_ack) state <= ST_RD_XFER;
                ST_RD_XFER: if (!sdram_rd_ack) begin
                    state       <= ST_IDLE;
                    last_served <= DIR_RD;
                end
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // A reload seen mid-burst is parked until the FSM is back in IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_addr     <= wr_b_addr;
            rd_addr     <= rd_b_addr;
            reload_pend <= 1'b0;
        end else begin
            if (reload_now) begin
                wr_addr <= wr_b_addr;
                rd_addr <= rd_b_addr;
            end else if (wr_done) begin
                wr_addr <= advance(wr_addr, wr_b_addr, wr_e_addr, wr_burst_len);
            end else if (rd_done) begin
                rd_addr <= advance(rd_addr, rd_b_addr, rd_e_addr, rd_burst_len);
            end
            if (wr_done || rd_done || state == ST_IDLE)
                reload_pend <= 1'b0;
            else if (addr_reload)
                reload_pend <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ovf <= 1'b0;
            rd_udf <= 1'b0;
        end else begin
            if (wr_fifo_wr_req && wr_full)
                wr_ovf <= 1'b1;
            else if (err_clr)
                wr_ovf <= 1'b0;
            if (rd_fifo_rd_req && rd_empty)
                rd_udf <= 1'b1;
            else if (err_clr)
                rd_udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_fifo_ctrl_param.sv
// Self-checking bench: table-driven write bursts plus hand sequences for
// arbitration, error flags, read-space gating, reset and deferred reload.
module tb_sdram_fifo_ctrl_param;

    localparam int DW = 16, AW = 12, DEPTH = 32, LW = 5, LVW = 6;

    logic           sys_clk, sys_rst, init_end, rd_enable, addr_reload, err_clr;
    logic [AW-1:0]  wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
    logic [LW-1:0]  wr_burst_len, rd_burst_len;
    logic [DW-1:0]  wr_fifo_wr_data, rd_fifo_rd_data, sdram_in_data, sdram_out_data;
    logic           wr_fifo_wr_req, rd_fifo_rd_req;
    logic [LVW-1:0] wr_fifo_num, rd_fifo_num;
    logic           sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [AW-1:0]  sdram_wr_addr, sdram_rd_addr;
    logic           wr_ovf, rd_udf;

    sdram_fifo_ctrl_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LW(LW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_enable(rd_enable),
        .addr_reload(addr_reload), .err_clr(err_clr),
        .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr), .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr),
        .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
        .wr_fifo_wr_data(wr_fifo_wr_data), .wr_fifo_wr_req(wr_fifo_wr_req), .wr_fifo_num(wr_fifo_num),
        .rd_fifo_rd_req(rd_fifo_rd_req), .rd_fifo_rd_data(rd_fifo_rd_data), .rd_fifo_num(rd_fifo_num),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack), .sdram_wr_addr(sdram_wr_addr),
        .sdram_in_data(sdram_in_data), .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_addr(sdram_rd_addr), .sdram_out_data(sdram_out_data),
        .wr_ovf(wr_ovf), .rd_udf(rd_udf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] b;
        logic [AW-1:0] e;
        logic [LW-1:0] len;
        bit            reload;
        logic [AW-1:0] exp_addr;
    } wr_vec_t;

    wr_vec_t       vecs [12];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            both_high = 0;
    logic [DW-1:0] wr_sb [$];
    logic [DW-1:0] rd_sb [$];
    logic [DW-1:0] data_ctr = 16'h0001;

    always @(negedge sys_clk) if (sdram_wr_req && sdram_rd_req) both_high++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] d, input bit store);
        wr_fifo_wr_data = d;
        wr_fifo_wr_req  = 1'b1;
        if (store) wr_sb.push_back(d);
        tick();
        wr_fifo_wr_req  = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(data_ctr, 1'b1);
            data_ctr++;
        end
    endtask

    task automatic do_reset();
        sdram_wr_ack = 0; sdram_rd_ack = 0; wr_fifo_wr_req = 0; rd_fifo_rd_req = 0;
        addr_reload = 0; err_clr = 0; init_end = 0;
        sys_rst = 1'b1;
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        wr_sb.delete();
        rd_sb.delete();
    endtask

    task automatic wait_req(input bit rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd ? sdram_rd_req : sdram_wr_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_output(rd ? "rd_req_seen" : "wr_req_seen", ok, 1);
    endtask

    task automatic serve_wr(input int len, input logic [AW-1:0] exp_addr);
        bit            ok;
        logic [DW-1:0] e;
        wait_req(1'b0, ok);
        if (!ok) return;
        check_output("wr_addr", sdram_wr_addr, exp_addr);
        sdram_wr_ack = 1'b1;
        for (int i = 0; i < len; i++) begin
            e = (wr_sb.size() != 0) ? wr_sb.pop_front() : '0;
            check_output("wr_data", sdram_in_data, e);
            tick();
            if (i == 0) check_output("wr_req_drop", sdram_wr_req, 0);
        end
        check_output("wr_addr_hold", sdram_wr_addr, exp_addr);
        sdram_wr_ack = 1'b0;
        tick();
    endtask

    task automatic serve_rd(input int len, input logic [AW-1:0] exp_addr);
        bit ok;
        wait_req(1'b1, ok);
        if (!ok) return;
        check_output("rd_addr", sdram_rd_addr, exp_addr);
        for (int i = 0; i < len; i++) begin
            sdram_rd_ack   = 1'b1;
            sdram_out_data = DW'($urandom);
            rd_sb.push_back(sdram_out_data);
            tick();
            if (i == 0) check_output("rd_req_drop", sdram_rd_req, 0);
        end
        sdram_rd_ack = 1'b0;
        tick();
    endtask

    task automatic pop_rd(input int n);
        logic [DW-1:0] e;
        for (int i = 0; i < n; i++) begin
            e = (rd_sb.size() != 0) ? rd_sb.pop_front() : '0;
            check_output("rd_data", rd_fifo_rd_data, e);
            rd_fifo_rd_req = 1'b1;
            tick();
            rd_fifo_rd_req = 1'b0;
        end
    endtask

    task automatic serve_any(input bit exp_rd, input logic [AW-1:0] exp_addr);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (sdram_wr_req || sdram_rd_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_output("grant_seen", ok, 1);
        if (!ok) return;
        check_output("grant_dir", sdram_rd_req, exp_rd);
        if (sdram_rd_req) serve_rd(8, exp_addr);
        else              serve_wr(8, exp_addr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{12'h100, 12'h118, 5'd8, 1'b0, 12'h100};
        vecs[1]  = '{12'h100, 12'h118, 5'd8, 1'b0, 12'h108};
        vecs[2]  = '{12'h100, 12'h118, 5'd8, 1'b0, 12'h110};
        vecs[3]  = '{12'h100, 12'h118, 5'd8, 1'b0, 12'h100};
        vecs[4]  = '{12'h100, 12'h114, 5'd8, 1'b1, 12'h100};
        vecs[5]  = '{12'h100, 12'h114, 5'd8, 1'b0, 12'h108};
        vecs[6]  = '{12'h100, 12'h114, 5'd8, 1'b0, 12'h100};
        vecs[7]  = '{12'h100, 12'h114, 5'd5, 1'b1, 12'h100};
        vecs[8]  = '{12'h100, 12'h114, 5'd5, 1'b0, 12'h105};
        vecs[9]  = '{12'h100, 12'h114, 5'd5, 1'b0, 12'h10A};
        vecs[10] = '{12'h100, 12'h114, 5'd5, 1'b0, 12'h10F};
        vecs[11] = '{12'h100, 12'h114, 5'd5, 1'b0, 12'h100};

        sys_rst = 1'b1; init_end = 0; rd_enable = 0; addr_reload = 0; err_clr = 0;
        wr_b_addr = 12'h100; wr_e_addr = 12'h118; rd_b_addr = 12'h200; rd_e_addr = 12'h280;
        wr_burst_len = 5'd8; rd_burst_len = 5'd0;
        wr_fifo_wr_data = '0; wr_fifo_wr_req = 0; rd_fifo_rd_req = 0;
        sdram_wr_ack = 0; sdram_rd_ack = 0; sdram_out_data = '0;
        do_reset();

        check_output("rst_wr_req", sdram_wr_req, 0);
        check_output("rst_rd_req", sdram_rd_req, 0);
        check_output("rst_wr_num", wr_fifo_num, 0);
        check_output("rst_rd_num", rd_fifo_num, 0);
        check_output("rst_wr_ovf", wr_ovf, 0);
        check_output("rst_rd_udf", rd_udf, 0);
        check_output("rst_wr_addr", sdram_wr_addr, 12'h100);
        check_output("rst_rd_addr", sdram_rd_addr, 12'h200);

        // Write bursts: data ordering, request timing and region wrap.
        init_end = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_b_addr    = vecs[i].b;
            wr_e_addr    = vecs[i].e;
            wr_burst_len = vecs[i].len;
            if (vecs[i].reload) begin
                addr_reload = 1'b1;
                tick();
                addr_reload = 1'b0;
            end
            push_words(int'(vecs[i].len));
            check_output("wr_req_early", sdram_wr_req, 0);
            check_output("wr_level", wr_fifo_num, vecs[i].len);
            tick();
            check_output("wr_req_rise", sdram_wr_req, 1);
            serve_wr(int'(vecs[i].len), vecs[i].exp_addr);
            check_output("wr_level_empty", wr_fifo_num, 0);
        end

        wr_burst_len = 5'd0;
        for (int k = 0; k < 3; k++) apply_stimulus(16'hBEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("wr_len0_no_req", sdram_wr_req, 0);
        end

        // Fair alternation with both directions eligible.
        wr_b_addr = 12'h100; wr_e_addr = 12'h118;
        do_reset();
        push_words(16);
        wr_burst_len = 5'd8; rd_burst_len = 5'd8; rd_enable = 1'b1; init_end = 1'b1;
        serve_any(1'b0, 12'h100);
        serve_any(1'b1, 12'h200);
        serve_any(1'b0, 12'h108);
        serve_any(1'b1, 12'h208);
        init_end = 1'b0;
        check_output("alt_rd_level", rd_fifo_num, 16);
        pop_rd(16);

        // Sticky error flags and clear priority.
        do_reset();
        for (int k = 0; k < DEPTH; k++) apply_stimulus(DW'(k), 1'b0);
        check_output("full_level", wr_fifo_num, DEPTH);
        check_output("ovf_before", wr_ovf, 0);
        apply_stimulus(16'hFFFF, 1'b0);
        check_output("ovf_set", wr_ovf, 1);
        check_output("ovf_level", wr_fifo_num, DEPTH);
        rd_fifo_rd_req = 1'b1; tick(); rd_fifo_rd_req = 1'b0;
        check_output("udf_set", rd_udf, 1);
        check_output("udf_level", rd_fifo_num, 0);
        err_clr = 1'b1; rd_fifo_rd_req = 1'b1; tick(); err_clr = 1'b0; rd_fifo_rd_req = 1'b0;
        check_output("clr_ovf", wr_ovf, 0);
        check_output("clr_vs_new_udf", rd_udf, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_output("clr_udf", rd_udf, 0);

        // Read-space gating and rd_enable.
        do_reset();
        wr_burst_len = 5'd0; rd_burst_len = 5'd17; rd_enable = 1'b1; init_end = 1'b1;
        serve_rd(17, 12'h200);
        rd_burst_len = 5'd16;
        check_output("rd_level_17", rd_fifo_num, 17);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("rd_space_no_req", sdram_rd_req, 0);
        end
        pop_rd(1);
        check_output("rd_level_16", rd_fifo_num, 16);
        check_output("rd_req_not_yet", sdram_rd_req, 0);
        tick();
        check_output("rd_req_after_pop", sdram_rd_req, 1);
        serve_rd(16, 12'h211);
        rd_enable = 1'b0;
        pop_rd(16);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output("rd_enable_blocks", sdram_rd_req, 0);
        end
        rd_enable = 1'b1;
        tick();
        check_output("rd_enable_req", sdram_rd_req, 1);
        serve_rd(16, 12'h221);
        rd_enable = 1'b0;
        pop_rd(32);

        // Reset mid-burst, stray acks and deferred reload.
        wr_b_addr = 12'h100; wr_e_addr = 12'h118; rd_b_addr = 12'h200;
        do_reset();
        wr_burst_len = 5'd8; rd_enable = 1'b0; init_end = 1'b1;
        sdram_wr_ack = 1'b1; sdram_rd_ack = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        sdram_wr_ack = 1'b0;
        check_output("stray_ack_level", wr_fifo_num, 0);
        check_output("stray_ack_ovf", wr_ovf, 0);
        check_output("stray_ack_udf", rd_udf, 0);
        push_words(8);
        tick();
        check_output("pre_rst_req", sdram_wr_req, 1);
        #2 sys_rst = 1'b1;
        #1 check_output("async_req_drop", sdram_wr_req, 0);
        tick();
        sys_rst = 1'b0;
        tick();
        wr_sb.delete();
        check_output("rst_req_level", wr_fifo_num, 0);

        push_words(8);
        tick();
        sdram_wr_ack = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        sys_rst = 1'b1; sdram_wr_ack = 1'b0;
        #1 check_output("xfer_rst_wr_req", sdram_wr_req, 0);
        check_output("xfer_rst_rd_req", sdram_rd_req, 0);
        tick();
        sys_rst = 1'b0;
        tick();
        wr_sb.delete();
        check_output("xfer_rst_wr_num", wr_fifo_num, 0);
        check_output("xfer_rst_rd_num", rd_fifo_num, 0);
        check_output("xfer_rst_wr_addr", sdram_wr_addr, 12'h100);

        push_words(8);
        check_output("idle_req_early", sdram_wr_req, 0);
        tick();
        check_output("idle_req_rise", sdram_wr_req, 1);
        check_output("reload_wr_addr0", sdram_wr_addr, 12'h100);
        sdram_wr_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_output("reload_wr_data", sdram_in_data, (wr_sb.size() != 0) ? wr_sb.pop_front() : '0);
            if (i == 2) begin
                wr_b_addr = 12'h300; wr_e_addr = 12'h318; rd_b_addr = 12'h240;
                addr_reload = 1'b1;
            end
            tick();
            addr_reload = 1'b0;
        end
        check_output("reload_wr_hold", sdram_wr_addr, 12'h100);
        check_output("reload_rd_hold", sdram_rd_addr, 12'h200);
        sdram_wr_ack = 1'b0;
        tick();
        check_output("reload_wr_applied", sdram_wr_addr, 12'h300);
        check_output("reload_rd_applied", sdram_rd_addr, 12'h240);

        check_output("req_overlap", both_high, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
